// File: rtl/lampfpu_sqrt_issue_if.sv
// rtl/lampfpu_sqrt_issue_if.sv - dispatch-side operand/result handshake bundle for lampfpu_sqrt_issue
interface lampfpu_sqrt_issue_if #(
   parameter int LAMP_FLOAT_DW = 16
);
   logic                     op_valid_i;
   logic                     op_ready_o;
   logic [LAMP_FLOAT_DW-1:0] op_i;
   logic                     res_valid_o;
   logic                     res_ready_i;
   logic [LAMP_FLOAT_DW-1:0] res_o;
   logic                     invalid_o;

   // dispatch logic / result consumer side
   modport master (
      output op_valid_i,
      output op_i,
      output res_ready_i,
      input  op_ready_o,
      input  res_valid_o,
      input  res_o,
      input  invalid_o
   );

   // issue stage side
   modport slave (
      input  op_valid_i,
      input  op_i,
      input  res_ready_i,
      output op_ready_o,
      output res_valid_o,
      output res_o,
      output invalid_o
   );
endinterface

// File: rtl/lampfpu_sqrt_issue.sv
// rtl/lampfpu_sqrt_issue.sv - bfloat16 sqrt issue/retire stage; optional LAMP_SQRT_SPECIAL_BYPASS_EN resolves specials locally
module lampfpu_sqrt_issue #(
   parameter int LAMP_FLOAT_DW   = 16,
   parameter int LAMP_FLOAT_E_DW = 8,
   parameter int LAMP_FLOAT_F_DW = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   lampfpu_sqrt_issue_if.slave        bus,
   output logic                       doSqrt_o,
   output logic                       signum_op_o,
   output logic [LAMP_FLOAT_E_DW-1:0] extExp_op_o,
   output logic [LAMP_FLOAT_F_DW:0]   extMant_op_o,
   output logic                       isZero_op_o,
   output logic                       isInf_op_o,
   output logic                       isSNAN_op_o,
   output logic                       isQNAN_op_o,
   input  logic                       sqrtValid_i,
   input  logic                       sqrtS_i,
   input  logic [LAMP_FLOAT_E_DW-1:0] sqrtE_i,
   input  logic [LAMP_FLOAT_F_DW-1:0] sqrtF_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQRT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                       accept;
   logic                       capture;

   // classification of the operand on the bus (only meaningful while accepting)
   logic                       in_s;
   logic [LAMP_FLOAT_E_DW-1:0] in_e;
   logic [LAMP_FLOAT_F_DW-1:0] in_f;
   logic                       in_zero;
   logic                       in_exp_max;
   logic                       in_inf;
   logic                       in_snan;
   logic                       in_qnan;
   logic                       in_invalid;

   logic [LAMP_FLOAT_DW-1:0]   res_q;
   logic                       invalid_q;

`ifdef LAMP_SQRT_SPECIAL_BYPASS_EN
   localparam logic [LAMP_FLOAT_DW-1:0] CANON_NAN = LAMP_FLOAT_DW'('h7FC0);
   localparam logic [LAMP_FLOAT_DW-1:0] POS_INF   = LAMP_FLOAT_DW'('h7F80);
   logic                       in_special;
   logic [LAMP_FLOAT_DW-1:0]   bypass_res;
`endif

   // unpack and classify the incoming operand; denormals classify as zero
   always_comb begin
      in_s       = bus.op_i[LAMP_FLOAT_DW-1];
      in_e       = bus.op_i[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
      in_f       = bus.op_i[LAMP_FLOAT_F_DW-1:0];
      in_zero    = (in_e == '0);
      in_exp_max = (in_e == '1);
      in_inf     = in_exp_max && (in_f == '0);
      in_snan    = in_exp_max && (in_f != '0) && !in_f[LAMP_FLOAT_F_DW-1];
      in_qnan    = in_exp_max && in_f[LAMP_FLOAT_F_DW-1];
      in_invalid = in_snan || (in_s && !in_zero && !(in_snan || in_qnan));
   end

`ifdef LAMP_SQRT_SPECIAL_BYPASS_EN
   // specials (zero, inf, NaN, any negative) never need the iterative unit
   always_comb begin
      in_special = in_zero || in_exp_max || in_s;
      if (in_zero)
         bypass_res = {in_s, {(LAMP_FLOAT_DW-1){1'b0}}};
      else if (in_inf && !in_s)
         bypass_res = POS_INF;
      else
         bypass_res = CANON_NAN;
   end
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // next-state and handshake strobes
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.op_valid_i) begin
               accept  = 1'b1;
`ifdef LAMP_SQRT_SPECIAL_BYPASS_EN
               state_d = in_special ? DONE : SQRT;
`else
               state_d = SQRT;
`endif
            end
         end
         SQRT: begin
            if (sqrtValid_i) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // operand/class registers feeding the sqrt unit, plus result and flag capture
   always_ff @(posedge clk) begin
      if (rst) begin
         signum_op_o  <= 1'b0;
         extExp_op_o  <= '0;
         extMant_op_o <= '0;
         isZero_op_o  <= 1'b0;
         isInf_op_o   <= 1'b0;
         isSNAN_op_o  <= 1'b0;
         isQNAN_op_o  <= 1'b0;
         invalid_q    <= 1'b0;
         res_q        <= '0;
      end else if (accept) begin
         signum_op_o  <= in_s;
         extExp_op_o  <= in_e;
         extMant_op_o <= in_zero ? '0 : {1'b1, in_f};
         isZero_op_o  <= in_zero;
         isInf_op_o   <= in_inf;
         isSNAN_op_o  <= in_snan;
         isQNAN_op_o  <= in_qnan;
         invalid_q    <= in_invalid;
`ifdef LAMP_SQRT_SPECIAL_BYPASS_EN
         res_q        <= bypass_res;
`endif
      end else if (capture) begin
         res_q        <= {sqrtS_i, sqrtE_i, sqrtF_i};
      end
   end

   // state-decoded handshake outputs; ready is masked while reset is held
   always_comb begin
      bus.op_ready_o  = (state_q == IDLE) && !rst;
      bus.res_valid_o = (state_q == DONE);
      bus.res_o       = res_q;
      bus.invalid_o   = invalid_q;
      doSqrt_o        = (state_q == SQRT);
   end

endmodule

// File: tb/tb_lampfpu_sqrt_issue.sv
// tb/tb_lampfpu_sqrt_issue.sv - randomized self-checking bench for lampfpu_sqrt_issue with a behavioural sqrt stub
module tb_lampfpu_sqrt_issue;

   logic clk_tb = 1'b0;
   logic rst;
   always #5 clk_tb = ~clk_tb;

   lampfpu_sqrt_issue_if bus ();

   logic       do_sqrt;
   logic       signum_op;
   logic [7:0] ext_exp;
   logic [7:0] ext_mant;
   logic       is_zero, is_inf, is_snan, is_qnan;
   logic       sqrt_valid;
   logic       sqrt_s;
   logic [7:0] sqrt_e;
   logic [6:0] sqrt_f;

   lampfpu_sqrt_issue dut (
      .clk          (clk_tb),
      .rst          (rst),
      .bus          (bus),
      .doSqrt_o     (do_sqrt),
      .signum_op_o  (signum_op),
      .extExp_op_o  (ext_exp),
      .extMant_op_o (ext_mant),
      .isZero_op_o  (is_zero),
      .isInf_op_o   (is_inf),
      .isSNAN_op_o  (is_snan),
      .isQNAN_op_o  (is_qnan),
      .sqrtValid_i  (sqrt_valid),
      .sqrtS_i      (sqrt_s),
      .sqrtE_i      (sqrt_e),
      .sqrtF_i      (sqrt_f)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // IEEE-style square root of a bfloat16 value, denormals treated as zero, truncated result
   function automatic logic [15:0] ref_sqrt(input logic [15:0] op);
      int          e;
      int          f;
      int          re;
      real         x;
      logic [63:0] b;
      e = int'(op[14:7]);
      f = int'(op[6:0]);
      if (e == 255 && f != 0) return 16'h7FC0;
      if (e == 0)             return {op[15], 15'h0};
      if (op[15])             return 16'h7FC0;
      if (e == 255)           return 16'h7F80;
      x = 1.0 + f / 128.0;
      for (int i = 0; i < e - 127; i++) x = x * 2.0;
      for (int i = 0; i < 127 - e; i++) x = x / 2.0;
      x  = $sqrt(x);
      b  = $realtobits(x);
      re = int'(b[62:52]) - 1023 + 127;
      return {1'b0, re[7:0], b[51:45]};
   endfunction

   function automatic logic ref_invalid(input logic [15:0] op);
      int e;
      int f;
      e = int'(op[14:7]);
      f = int'(op[6:0]);
      if (e == 255 && f != 0) return (f < 64);
      return op[15] && (e != 0);
   endfunction

   function automatic logic ref_special(input logic [15:0] op);
      return op[15] || (op[14:7] == 8'd0) || (op[14:7] == 8'd255);
   endfunction

   // {sign, exp, mant, zero, inf, snan, qnan} expected on the sqrt-unit side
   function automatic logic [20:0] ref_class(input logic [15:0] op);
      int         e;
      int         f;
      logic [7:0] mant;
      e    = int'(op[14:7]);
      f    = int'(op[6:0]);
      mant = (e == 0) ? 8'h00 : (8'h80 + 8'(f));
      return {op[15], op[14:7], mant, (e == 0), (e == 255 && f == 0),
              (e == 255 && f != 0 && f < 64), (e == 255 && f >= 64)};
   endfunction

   function automatic logic [31:0] all_outputs();
      return {bus.op_ready_o, bus.res_valid_o, bus.invalid_o, do_sqrt, bus.res_o,
              signum_op, ext_exp, is_zero, is_inf, is_snan, is_qnan} | {24'h0, ext_mant};
   endfunction

   task automatic run_op(input logic [15:0] op, input int lat, input int bp);
      logic [15:0] exp_res;
      logic        exp_inv;
      logic        byp;
      exp_res = ref_sqrt(op);
      exp_inv = ref_invalid(op);
`ifdef LAMP_SQRT_SPECIAL_BYPASS_EN
      byp = ref_special(op);
`else
      byp = 1'b0;
`endif
      @(negedge clk_tb);
      check("op_ready_idle", bus.op_ready_o, 1);
      bus.op_valid_i = 1'b1;
      bus.op_i       = op;
      @(posedge clk_tb);
      #1;
      bus.op_i = 16'($urandom);
      @(negedge clk_tb);
      check("op_ready_busy", bus.op_ready_o, 0);
      if (!byp) begin
         for (int c = 0; c < lat; c++) begin
            if (c > 0) @(negedge clk_tb);
            check("do_sqrt_hi", do_sqrt, 1);
            check("class_out", {signum_op, ext_exp, ext_mant, is_zero, is_inf, is_snan, is_qnan},
                  ref_class(op));
            check("res_valid_lo", bus.res_valid_o, 0);
            check("op_ready_sqrt", bus.op_ready_o, 0);
            if (c == lat - 1) begin
               sqrt_valid = 1'b1;
               {sqrt_s, sqrt_e, sqrt_f} = exp_res;
            end else begin
               {sqrt_s, sqrt_e, sqrt_f} = 16'($urandom);
            end
         end
         @(negedge clk_tb);
         sqrt_valid = 1'b0;
         {sqrt_s, sqrt_e, sqrt_f} = 16'($urandom);
         check("do_sqrt_drop", do_sqrt, 0);
      end
      check("res_valid_hi", bus.res_valid_o, 1);
      for (int b = 0; b <= bp; b++) begin
         if (b > 0) @(negedge clk_tb);
         check("res_o", bus.res_o, exp_res);
         check("invalid_o", bus.invalid_o, exp_inv);
         check("res_valid_hold", bus.res_valid_o, 1);
         check("op_ready_done", bus.op_ready_o, 0);
         check("do_sqrt_done", do_sqrt, 0);
      end
      bus.res_ready_i = 1'b1;
      bus.op_valid_i  = 1'b0;
      @(negedge clk_tb);
      bus.res_ready_i = 1'b0;
      check("res_valid_after", bus.res_valid_o, 0);
      check("op_ready_after", bus.op_ready_o, 1);
   endtask

   function automatic logic [15:0] rand_op();
      logic [15:0] op;
      logic [6:0]  f;
      f = 7'($urandom);
      case ($urandom_range(0, 5))
         0: op = {1'b0, 8'($urandom_range(1, 254)), f};
         1: op = {1'b1, 8'($urandom_range(1, 254)), f};
         2: op = {1'($urandom), 15'h0};
         3: op = {1'($urandom), 8'h00, (f == 0) ? 7'h01 : f};
         4: op = {1'($urandom), 8'hFF, 7'h00};
         default: op = {1'($urandom), 8'hFF, (f == 0) ? 7'h21 : f};
      endcase
      return op;
   endfunction

   logic [15:0] directed [10];

   initial begin
      directed = '{16'h4080, 16'h3F80, 16'hC080, 16'h7F81, 16'h8000,
                   16'h7F80, 16'h0001, 16'h7FC0, 16'hFF80, 16'h3E80};
      rst             = 1'b1;
      bus.op_valid_i  = 1'b0;
      bus.op_i        = 16'h0;
      bus.res_ready_i = 1'b0;
      sqrt_valid      = 1'b0;
      {sqrt_s, sqrt_e, sqrt_f} = 16'h0;
      repeat (3) @(negedge clk_tb);
      check("reset_outputs", all_outputs(), 0);
      rst = 1'b0;

      foreach (directed[i])
         run_op(directed[i], (i % 4) + 1, (i == 1) ? 3 : (i % 3));

      // reset during SQRT discards the operation
      @(negedge clk_tb);
      bus.op_valid_i = 1'b1;
      bus.op_i       = 16'h4080;
      @(negedge clk_tb);
      bus.op_valid_i = 1'b0;
      check("rst_pre_sqrt", do_sqrt, 1);
      @(negedge clk_tb);
      rst = 1'b1;
      @(negedge clk_tb);
      check("rst_mid_outputs", all_outputs(), 0);
      rst = 1'b0;
      @(negedge clk_tb);
      check("rst_op_ready", bus.op_ready_o, 1);
      check("rst_res_valid", bus.res_valid_o, 0);

      // a stray sqrt valid in IDLE must not produce a result
      sqrt_valid = 1'b1;
      {sqrt_s, sqrt_e, sqrt_f} = 16'h1234;
      @(negedge clk_tb);
      sqrt_valid = 1'b0;
      check("stray_res_valid", bus.res_valid_o, 0);
      check("stray_do_sqrt", do_sqrt, 0);
      @(negedge clk_tb);
      check("stray_res_valid2", bus.res_valid_o, 0);

      for (int n = 0; n < 40; n++)
         run_op(rand_op(), $urandom_range(1, 6), $urandom_range(0, 3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lampfpu_sqrt_issue.md
# lampfpu_sqrt_issue

Issue/retire stage wrapped around `lampFPU_sqrt`.
- Accepts one packed bfloat16 operand over a valid/ready handshake, then unpacks and classifies it.
- Drives the sqrt unit's operand and class inputs and holds `doSqrt` until the unit reports valid.
- Packs `{s,e,f}` into a 16-bit result and holds it under a valid/ready handshake until consumed.
- One operation in flight; sits between the FPU dispatch logic and `lampFPU_sqrt`.

## Interface
Parameters:
- `LAMP_FLOAT_DW`, 16 (from `lampFPU_pkg`): packed operand/result width.
- `LAMP_FLOAT_E_DW`, 8; `LAMP_FLOAT_F_DW`, 7 (from `lampFPU_pkg`): exponent and fraction widths.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid_i`  in  1  operand offered.
- `op_ready_o`  out  1  operand accepted when high together with `op_valid_i`.
- `op_i`  in  16  packed bfloat16 operand `{s[15], e[14:7], f[6:0]}`.
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  consumer takes the result.
- `res_o`  out  16  packed result.
- `invalid_o`  out  1  IEEE invalid flag; qualified by `res_valid_o`.
- `doSqrt_o`  out  1  to sqrt `doSqrt_i`.
- `signum_op_o`  out  1  to sqrt unit.
- `extExp_op_o`  out  8  to sqrt unit.
- `extMant_op_o`  out  8  to sqrt unit: `{hidden, f}`.
- `isZero_op_o`, `isInf_op_o`, `isSNAN_op_o`, `isQNAN_op_o`  out  1 each  class flags to the sqrt unit.
- `sqrtValid_i`  in  1  from sqrt `valid_o`.
- `sqrtS_i`  in  1  sqrt result sign.
- `sqrtE_i`  in  8  sqrt result exponent.
- `sqrtF_i`  in  7  sqrt result fraction.

## Operation
FSM states: IDLE, SQRT, DONE.

- **IDLE**
  - `op_ready_o`=1 (0 while `rst`=1).
  - On `op_valid_i`: register the operand and its class, then go to SQRT. With bypass enabled and a special class, go to DONE instead.
- **SQRT**
  - `doSqrt_o`=1; operand and class outputs held stable.
  - On `sqrtValid_i`=1: capture `{sqrtS_i, sqrtE_i, sqrtF_i}` into `res_o`, then go to DONE.
- **DONE**
  - `res_valid_o`=1; `res_o` and `invalid_o` held stable.
  - On `res_ready_i`: go to IDLE.

Classification of a captured operand `e`/`f`:
- Zero: `e`==0. Denormals are flushed to a signed zero, so `extMant`=0.
- Inf: `e`==0xFF, `f`==0.
- sNaN: `e`==0xFF, `f`!=0, `f[6]`==0.
- qNaN: `e`==0xFF, `f[6]`==1.
- Hidden bit = (`e`!=0).
- `extExp_op_o` = `e`.

Invalid flag:
- `invalid_o` = sNaN | (sign & !zero & !NaN).
- Computed in this block regardless of configuration.

Other rules:
- `sqrtValid_i` is ignored outside SQRT.
- `op_valid_i` is ignored outside IDLE.
- Canonical NaN is 0x7FC0.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset mid-operation: IDLE at the next edge, `doSqrt_o` drops, any pending result is discarded. The sqrt unit shares `rst`.
- Operand accepted at edge k.
- Sqrt path:
  - `doSqrt_o` high from k+1 until the edge at which `sqrtValid_i` is sampled; low in the following cycle.
  - `res_valid_o` high the cycle after `sqrtValid_i` is sampled.
- Bypass path: `res_valid_o` high at k+1.
- `res_valid_o` deasserts the cycle after the handshake. `op_ready_o` returns in that same cycle, so there is no back-to-back acceptance.
- Throughput: sqrt latency + 2 cycles per operation.

## Configuration
Macro `LAMP_SQRT_SPECIAL_BYPASS_EN`.

Defined: specials are resolved locally and the sqrt unit is never started for them.
- Zero → signed zero.
- +Inf → 0x7F80.
- NaN or negative nonzero → 0x7FC0.

Undefined:
- Every operand goes through SQRT with its class flags set.
- `res_o` comes from the sqrt unit.
- `invalid_o` is still generated locally.

## Test plan
- 0x4080 (4.0) → `res_o`=0x4000, `invalid_o`=0. `doSqrt_o` drops the cycle after `sqrtValid_i`.
- 0x3F80 (1.0) → `res_o`=0x3F80. `op_ready_o`=0 from acceptance until after the result handshake.
- 0xC080 (-4.0) → 0x7FC0, `invalid_o`=1. 0x7F81 (sNaN) → 0x7FC0, `invalid_o`=1.
  - Bypass build: `res_valid_o` at k+1 and `doSqrt_o` never asserts.
- 0x8000 → 0x8000, 0x7F80 → 0x7F80, 0x0001 (denormal) → 0x0000, all with `invalid_o`=0. Non-bypass build: `isZero_op_o`/`isInf_op_o` set while `doSqrt_o`=1.
- Backpressure: `res_ready_i`=0 for 3 cycles → `res_o` stable, `res_valid_o`=1, `op_ready_o`=0. Handshake → IDLE next cycle.
- `rst` pulsed during SQRT → next cycle all outputs 0. A stray `sqrtValid_i` in IDLE produces no result.
